// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared types and constants for the single-wire serial link (transmitter now,
// receiver later).
//   tx_state_t  : transmitter frame states
//   LINE_IDLE   : level of the line between frames
//   START_BIT   : level driven for the start bit
//   STOP_BIT    : level driven for the stop bit
//   clog2_min1  : counter width for a range, never narrower than one bit
// ---------------------------------------------------------------------------
package ser_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // $clog2(1) is 0, which would give a zero-width counter.
   function automatic int clog2_min1(input int value);
      int w;
      w = $clog2(value);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ser_baud_tick.sv
// ---------------------------------------------------------------------------
// ser_baud_tick
// Baud counter that marks the last clk cycle of each bit period.
//   clk   in  : clock, state updates on posedge
//   rst   in  : synchronous active-high reset, clears the count
//   clear in  : restart the count at 0 on the next cycle (state entry)
//   tick  out : high while the count equals CLKS_PER_BIT-1
// With CLKS_PER_BIT=1 the count stays at 0 and tick is constantly high.
// ---------------------------------------------------------------------------
module ser_baud_tick
   import ser_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int               CNT_W   = clog2_min1(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_MAX);

   // Wrap on tick so the count never runs past CLKS_PER_BIT-1.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ser_tx.sv
// ---------------------------------------------------------------------------
// ser_tx
// Parallel-to-serial line transmitter. Frame on txd: start bit (0), WIDTH data
// bits LSB first, optional even parity bit, stop bit (1). Each bit is held for
// CLKS_PER_BIT clk cycles.
//   clk      in  : clock, state updates on posedge
//   rst      in  : synchronous active-high reset, aborts any frame in flight
//   in_data  in  : word to send, sampled only on the accept edge
//   in_valid in  : producer has a word
//   in_ready out : transmitter idle and able to accept
//   txd      out : serial line, registered, idles at 1
//   busy     out : high from the accept edge until the stop bit has ended
//   done     out : one-cycle pulse on the idle cycle after the stop bit
// Handshake: a word is taken on any posedge where in_valid and in_ready are
// both high; in_valid while in_ready is low is ignored and must be held by the
// producer until it is taken.
// ---------------------------------------------------------------------------
module ser_tx
   import ser_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             txd,
   output logic             busy,
   output logic             done
);

   localparam int               BIT_W    = clog2_min1(WIDTH);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

   tx_state_t        state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [BIT_W-1:0] bit_q;
   logic             parity_q;
   logic             txd_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             done_q;

   logic accept;
   logic tick;
   logic baud_clear;

   assign accept = in_ready_q & in_valid;

   // Restart the bit period on every state entry: the accept edge and every
   // edge where a non-idle state ends.
   assign baud_clear = accept | ((state_q != IDLE) & tick);

   ser_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clear(baud_clear),
      .tick (tick)
   );

   // The shift register is consumed at its LSB: each time a data bit is put
   // on the line the register moves right, so shreg_q[0] is always the next bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_q      <= '0;
         parity_q   <= 1'b0;
         txd_q      <= LINE_IDLE;
         in_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  shreg_q    <= in_data;
                  parity_q   <= ^in_data;
                  bit_q      <= '0;
                  state_q    <= START;
                  txd_q      <= START_BIT;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  state_q <= DATA;
                  txd_q   <= shreg_q[0];
                  shreg_q <= shreg_q >> 1;
                  bit_q   <= '0;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_q == LAST_BIT) begin
                     if (PARITY_EN != 0) begin
                        state_q <= PARITY;
                        txd_q   <= parity_q;
                     end else begin
                        state_q <= STOP;
                        txd_q   <= STOP_BIT;
                     end
                  end else begin
                     bit_q   <= bit_q + BIT_W'(1);
                     txd_q   <= shreg_q[0];
                     shreg_q <= shreg_q >> 1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  state_q <= STOP;
                  txd_q   <= STOP_BIT;
               end
            end
            STOP: begin
               if (tick) begin
                  state_q    <= IDLE;
                  txd_q      <= LINE_IDLE;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
               end
            end
            default: begin
               state_q    <= IDLE;
               txd_q      <= LINE_IDLE;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign txd      = txd_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_ser_tx.sv
// ---------------------------------------------------------------------------
// tb_ser_tx
// Bench for ser_tx. The main instance (WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=1)
// is checked by a scoreboard: the driver pushes each accepted word into
// exp_q, and a monitor captures every frame cycle by cycle and compares it
// against a frame built from the word with plain arithmetic. A second
// instance (CLKS_PER_BIT=1, PARITY_EN=0) gets a directed single-frame check.
// Valid/ready: a word is taken on a posedge where in_valid and in_ready are
// both high; inputs are driven on negedges, outputs sampled 1 ns after posedge.
// ---------------------------------------------------------------------------
module tb_ser_tx;

   localparam int W   = 8;
   localparam int CPB = 4;
   localparam int PEN = 1;
   localparam int NB  = 2 + W + PEN;
   localparam int F   = NB * CPB;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         txd;
   logic         busy;
   logic         done;

   logic         in_valid1;
   logic [W-1:0] in_data1;
   logic         in_ready1;
   logic         txd1;
   logic         busy1;
   logic         done1;

   ser_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(PEN)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .txd     (txd),
      .busy    (busy),
      .done    (done)
   );

   ser_tx #(.WIDTH(W), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
      .clk     (clk),
      .rst     (rst),
      .in_data (in_data1),
      .in_valid(in_valid1),
      .in_ready(in_ready1),
      .txd     (txd1),
      .busy    (busy1),
      .done    (done1)
   );

   // scoreboard state
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];
   int           cyc = 0;
   int           last_done_cyc = -100;
   int           last_gap = 0;
   bit           collecting = 1'b0;
   bit           busy_all = 1'b1;
   int           n = 0;
   logic [F-1:0] cap;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference frame: per-bit levels, each repeated CPB times.
   function automatic logic [F-1:0] frame_model(input logic [W-1:0] d);
      logic [NB-1:0] bits;
      logic [F-1:0]  v;
      bits[0] = 1'b0;
      for (int i = 0; i < W; i++) bits[1 + i] = d[i];
      if (PEN != 0) bits[W + 1] = ^d;
      bits[NB - 1] = 1'b1;
      for (int c = 0; c < F; c++) v[c] = bits[c / CPB];
      return v;
   endfunction

   // monitor
   always @(posedge clk) begin
      logic [W-1:0] e;
      #1;
      cyc++;
      if (rst) begin
         if (collecting) begin
            collecting = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         chk("reset_outputs", {txd, in_ready, busy, done}, 4'b1100);
      end else if (!collecting) begin
         if (busy) begin
            collecting = 1'b1;
            busy_all   = 1'b1;
            cap        = '0;
            cap[0]     = txd;
            n          = 1;
            last_gap   = cyc - last_done_cyc;
         end else begin
            chk("idle_outputs", {txd, in_ready, done}, 3'b110);
         end
      end else if (n < F) begin
         busy_all = busy_all & busy;
         cap[n]   = txd;
         n++;
      end else begin
         chk("busy_whole_frame", busy_all, 1);
         chk("end_outputs", {done, busy, in_ready, txd}, 4'b1011);
         if (exp_q.size() == 0) begin
            chk("frame_without_accept", 0, 1);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("frame_%02h", e), cap, frame_model(e));
         end
         last_done_cyc = cyc;
         collecting    = 1'b0;
      end
   end

   // driver tasks
   task automatic send(input logic [W-1:0] d);
      int guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(d);
      @(posedge clk);
      #1;
      chk("accept_latency", {busy, txd, in_ready}, 3'b100);
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic noise_while_busy();
      int guard = 0;
      @(negedge clk);
      while (busy && guard < 500) begin
         in_valid = ~in_valid;
         in_data  = W'($urandom);
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((exp_q.size() != 0 || collecting) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("drain", (exp_q.size() == 0 && !collecting), 1);
   endtask

   // stimulus
   initial begin
      logic [15:0]  fseq;
      logic [15:0]  fdone;
      logic [15:0]  fexp;
      logic [W-1:0] d;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_valid1 = 1'b0;
      in_data1  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(10);

      // single frame
      send(8'hA5);
      idle(1);
      drain();

      // back-to-back with held valid
      send(8'h07);
      send(8'hFF);
      idle(1);
      drain();
      chk("b2b_gap", last_gap, 1);

      // mid-frame reset during the third data bit
      send(8'h3C);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(3);
      send(8'h81);
      idle(1);
      drain();

      // input activity while busy is ignored
      send(8'h5A);
      noise_while_busy();
      drain();

      // random words with random gaps
      for (int i = 0; i < 20; i++) begin
         d = W'($urandom);
         send(d);
         if ($urandom_range(0, 2) == 0) noise_while_busy();
         else idle($urandom_range(0, 3));
      end
      idle(1);
      drain();

      // one bit per cycle, no parity
      @(negedge clk);
      in_valid1 = 1'b1;
      in_data1  = 8'h01;
      chk("fast_ready", in_ready1, 1);
      @(negedge clk);
      in_valid1 = 1'b0;
      fseq  = '0;
      fdone = '0;
      for (int k = 0; k < 11; k++) begin
         fseq[k]  = txd1;
         fdone[k] = done1;
         @(negedge clk);
      end
      fexp    = '0;
      fexp[0] = 1'b0;
      for (int i = 0; i < W; i++) fexp[1 + i] = in_data1[i];
      fexp[W + 1] = 1'b1;
      fexp[W + 2] = 1'b1;
      chk("fast_txd_seq", fseq[10:0], fexp[10:0]);
      chk("fast_done_at_11", fdone[10:0], 11'h400);

      idle(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
